// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and helpers for the FIFO burst reader.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_burst_reader_pkg;

    // The state records what the one-word pend slot is holding.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // pend empty
        S_HOLD  = 2'd1,   // pend holds a beat that is not the burst end (yet)
        S_FINAL = 2'd2    // pend holds the last beat of the current burst
    } state_e;

    localparam int STAT_W = 16;

    // Bits needed to count from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count visible one cycle after inc_i/clr_i.
// Backpressure: none; holds at MAX while inc_i stays high.
// Ports: clk_i, rst_ni (async active-low), clr_i, inc_i, cnt_o[W-1:0].
module sat_counter #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO into a valid/ready stream, marking burst ends with m_last_o.
// Latency: a popped word reaches m_* one cycle after its successor is popped, the burst fills, or the idle timeout hits.
// Backpressure: m_ready_i low with out and pend slots full stops popping; the idle timer keeps counting.
// Ports: clk_i, rst_ni; FIFO side fifo_empty_i, fifo_rd_data_i, fifo_rd_en_o;
//   stream side m_valid_o, m_data_o, m_last_o, m_ready_i.
// Build option: FIFO_BURST_READER_STATS_EN adds bursts_o/flushes_o saturating counters.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rd_data_i,
    output logic             fifo_rd_en_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_last_o,
    input  logic             m_ready_i
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    output logic [15:0]      bursts_o,
    output logic [15:0]      flushes_o
`endif
);

    localparam int            CW = cnt_width(BURST_LEN);
    localparam int            TW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] BL = CW'(BURST_LEN);
    localparam logic [TW-1:0] TO = TW'(TIMEOUT);

    state_e           state_q;
    logic [WIDTH-1:0] pend_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_inc;
    logic [TW-1:0]    timer;

    logic out_free;
    logic pop;
    logic move;       // pend -> out this cycle
    logic move_last;  // the moved beat closes the burst
    logic flush;      // timeout-terminated burst end

    assign out_free = !m_valid_o || m_ready_i;
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        pop   = 1'b0;
        move  = 1'b0;
        flush = 1'b0;
        case (state_q)
            S_IDLE: begin
                pop = !fifo_empty_i;
            end
            S_HOLD: begin
                // A fresh word always beats the timeout: the held beat is then not last.
                pop   = out_free && !fifo_empty_i;
                flush = out_free && fifo_empty_i && (timer == TO);
                move  = pop || flush;
            end
            S_FINAL: begin
                pop  = out_free && !fifo_empty_i;
                move = out_free;
            end
            default: ;
        endcase
    end

    assign move_last    = (state_q == S_FINAL) || flush;
    assign fifo_rd_en_o = pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            cnt_q     <= '0;
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_last_o  <= 1'b0;
        end else begin
            // Out slot only changes when empty or being accepted, so a stalled beat stays put.
            if (out_free) begin
                m_valid_o <= move;
                if (move) begin
                    m_data_o <= pend_q;
                    m_last_o <= move_last;
                end
            end

            if (pop) begin
                pend_q <= fifo_rd_data_i;
            end

            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (pop) begin
                        cnt_q   <= cnt_inc;
                        state_q <= (cnt_inc == BL) ? S_FINAL : S_HOLD;
                    end else if (flush) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                S_FINAL: begin
                    if (move) begin
                        if (pop) begin
                            // Same-cycle pop opens the next burst.
                            cnt_q   <= CW'(1);
                            state_q <= (BL == CW'(1)) ? S_FINAL : S_HOLD;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Idle timer only runs while a non-final beat waits for a successor.
    sat_counter #(
        .W   (TW),
        .MAX (TO)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (pop || (state_q != S_HOLD)),
        .inc_i  ((state_q == S_HOLD) && fifo_empty_i),
        .cnt_o  (timer)
    );

`ifdef FIFO_BURST_READER_STATS_EN
    sat_counter #(
        .W   (STAT_W),
        .MAX (16'hFFFF)
    ) u_bursts (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .inc_i  (m_valid_o && m_ready_i && m_last_o),
        .cnt_o  (bursts_o)
    );

    sat_counter #(
        .W   (STAT_W),
        .MAX (16'hFFFF)
    ) u_flushes (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .inc_i  (flush),
        .cnt_o  (flushes_o)
    );
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: BURST_LEN=4 instance plus a BURST_LEN=1 instance.
// Latency: n/a (testbench).
// Backpressure: bench drives m_ready_i patterns directly.
module tb_fifo_burst_reader;

    localparam int W   = 8;
    localparam int LOG = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: BURST_LEN=4, TIMEOUT=8 ----------------
    logic [W-1:0] a_mem [256];
    int           a_wr = 0;
    int           a_rd = 0;
    logic         a_gate;
    logic         a_empty;
    logic [W-1:0] a_rdata;
    logic         a_rd_en, a_mv, a_ml, a_mr;
    logic [W-1:0] a_md;

    assign a_empty = (a_wr == a_rd) || a_gate;
    assign a_rdata = a_mem[a_rd[7:0]];
    always @(posedge clk) if (a_rd_en) a_rd <= a_rd + 1;

    // ---------------- instance B: BURST_LEN=1 ----------------
    logic [W-1:0] b_mem [4];
    int           b_wr = 0;
    int           b_rd = 0;
    logic         b_empty;
    logic [W-1:0] b_rdata;
    logic         b_rd_en, b_mv, b_ml, b_mr;
    logic [W-1:0] b_md;

    assign b_empty = (b_wr == b_rd);
    assign b_rdata = b_mem[b_rd[1:0]];
    always @(posedge clk) if (b_rd_en) b_rd <= b_rd + 1;

`ifdef FIFO_BURST_READER_STATS_EN
    logic [15:0] a_bursts, a_flushes, b_bursts, b_flushes;
`endif

    fifo_burst_reader #(.WIDTH(W), .BURST_LEN(4), .TIMEOUT(8)) u_a (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .fifo_empty_i   (a_empty),
        .fifo_rd_data_i (a_rdata),
        .fifo_rd_en_o   (a_rd_en),
        .m_valid_o      (a_mv),
        .m_data_o       (a_md),
        .m_last_o       (a_ml),
        .m_ready_i      (a_mr)
`ifdef FIFO_BURST_READER_STATS_EN
        ,
        .bursts_o       (a_bursts),
        .flushes_o      (a_flushes)
`endif
    );

    fifo_burst_reader #(.WIDTH(W), .BURST_LEN(1), .TIMEOUT(8)) u_b (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .fifo_empty_i   (b_empty),
        .fifo_rd_data_i (b_rdata),
        .fifo_rd_en_o   (b_rd_en),
        .m_valid_o      (b_mv),
        .m_data_o       (b_md),
        .m_last_o       (b_ml),
        .m_ready_i      (b_mr)
`ifdef FIFO_BURST_READER_STATS_EN
        ,
        .bursts_o       (b_bursts),
        .flushes_o      (b_flushes)
`endif
    );

    // ---------------- monitors: log accepted beats, sampled at negedge ----------------
    logic [W-1:0] a_obs_d [LOG];
    logic         a_obs_l [LOG];
    int           a_obs_c [LOG];
    int           a_n = 0;
    logic [W-1:0] b_obs_d [16];
    logic         b_obs_l [16];
    int           b_obs_c [16];
    int           b_n = 0;
    int           viol = 0;

    always @(negedge clk) begin
        if (a_mv && a_mr && a_n < LOG) begin
            a_obs_d[a_n] = a_md;
            a_obs_l[a_n] = a_ml;
            a_obs_c[a_n] = cyc;
            a_n = a_n + 1;
        end
        if (b_mv && b_mr && b_n < 16) begin
            b_obs_d[b_n] = b_md;
            b_obs_l[b_n] = b_ml;
            b_obs_c[b_n] = cyc;
            b_n = b_n + 1;
        end
        if ((a_rd_en && a_empty) || (b_rd_en && b_empty)) viol = viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [W-1:0] v);
        a_mem[a_wr[7:0]] = v;
        a_wr = a_wr + 1;
    endtask

    task automatic push_b(input logic [W-1:0] v);
        b_mem[b_wr[1:0]] = v;
        b_wr = b_wr + 1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int rd0;
        int seq;
        int bad_order;
        int bad_len;
        int run;

        rst_n  = 1'b0;
        a_gate = 1'b0;
        a_mr   = 1'b1;
        b_mr   = 1'b1;
        step(3);

        // Reset state
        check("rst_valid", a_mv, 1'b0);
        check("rst_last", a_ml, 1'b0);
        check("rst_data", a_md, 8'h00);
        check("rst_rd_en", a_rd_en, 1'b0);
        check("rst_cnt", u_a.cnt_q, 0);
        rst_n = 1'b1;
        step(2);

        // Two full bursts back-to-back
        base = a_n;
        for (int i = 0; i < 8; i++) push_a(8'h10 + 8'(i));
        step(15);
        check("full_count", a_n - base, 8);
        for (int k = 0; k < 8; k++) begin
            check("full_data", a_obs_d[base + k], 8'h10 + 8'(k));
            check("full_last", a_obs_l[base + k], (k == 3 || k == 7) ? 1'b1 : 1'b0);
        end
        check("full_streaming", a_obs_c[base + 7] - a_obs_c[base], 7);

        // Partial burst closed by the idle timeout
        base = a_n;
        push_a(8'hA0);
        push_a(8'hA1);
        step(20);
        check("to_count", a_n - base, 2);
        check("to_data0", a_obs_d[base], 8'hA0);
        check("to_last0", a_obs_l[base], 1'b0);
        check("to_data1", a_obs_d[base + 1], 8'hA1);
        check("to_last1", a_obs_l[base + 1], 1'b1);
        check("to_delay", a_obs_c[base + 1] - a_obs_c[base], 9);
`ifdef FIFO_BURST_READER_STATS_EN
        check("stat_flushes", a_flushes, 16'd1);
        check("stat_bursts", a_bursts, 16'd3);
`endif

        // Backpressure: stall with both slots full, then release
        a_mr = 1'b0;
        base = a_n;
        rd0  = a_rd;
        for (int i = 0; i < 6; i++) push_a(8'hB0 + 8'(i));
        step(20);
        check("bp_pops", a_rd - rd0, 2);
        check("bp_valid", a_mv, 1'b1);
        check("bp_data", a_md, 8'hB0);
        check("bp_last", a_ml, 1'b0);
        a_mr = 1'b1;
        step(25);
        check("bp_count", a_n - base, 6);
        for (int k = 0; k < 6; k++) begin
            check("bp_order", a_obs_d[base + k], 8'hB0 + 8'(k));
            check("bp_lastpat", a_obs_l[base + k], (k == 3 || k == 5) ? 1'b1 : 1'b0);
        end

        // BURST_LEN=1: every beat is last, no timer wait
        push_b(8'h55);
        push_b(8'h66);
        step(6);
        check("b1_count", b_n, 2);
        check("b1_data0", b_obs_d[0], 8'h55);
        check("b1_data1", b_obs_d[1], 8'h66);
        check("b1_last0", b_obs_l[0], 1'b1);
        check("b1_last1", b_obs_l[1], 1'b1);
        check("b1_gap", b_obs_c[1] - b_obs_c[0], 1);

        // Reset while a beat is pending
        a_mr = 1'b0;
        push_a(8'hC0);
        push_a(8'hC1);
        step(4);
        check("mid_pending", a_mv, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", a_mv, 1'b0);
        check("mid_rst_last", a_ml, 1'b0);
        check("mid_rst_cnt", u_a.cnt_q, 0);
        step(1);
        rst_n = 1'b1;
        a_mr  = 1'b1;
        base  = a_n;
        for (int i = 0; i < 4; i++) push_a(8'hD0 + 8'(i));
        step(12);
        check("post_rst_count", a_n - base, 4);
        for (int k = 0; k < 4; k++) begin
            check("post_rst_data", a_obs_d[base + k], 8'hD0 + 8'(k));
            check("post_rst_last", a_obs_l[base + k], (k == 3) ? 1'b1 : 1'b0);
        end

        // Random ready / empty against an in-order scoreboard
        base = a_n;
        seq  = 0;
        for (int c = 0; c < 3000; c++) begin
            a_gate = ($urandom_range(0, 3) == 0);
            a_mr   = ($urandom_range(0, 3) != 0);
            if ((a_wr - a_rd) < 200 && $urandom_range(0, 1) == 1) begin
                push_a(8'(seq));
                seq++;
            end
            step(1);
        end
        a_gate = 1'b0;
        a_mr   = 1'b1;
        step(40);
        check("rnd_count", a_n - base, seq);
        bad_order = 0;
        bad_len   = 0;
        run       = 0;
        for (int k = 0; k < a_n - base; k++) begin
            if (a_obs_d[base + k] !== 8'(k)) bad_order++;
            run++;
            if (a_obs_l[base + k]) begin
                if (run > 4) bad_len++;
                run = 0;
            end else if (run >= 4) begin
                bad_len++;
            end
        end
        if (run != 0) bad_len++;
        check("rnd_order", bad_order, 0);
        check("rnd_burst_len", bad_len, 0);
        check("rd_en_while_empty", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
